serializer_piso: RTL and testbench

Parallel-in/serial-out serializer that accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock, LSB first. It sits directly upstream of the 4-stage serial shift register and drives that block's single-bit `in` input. A frame-marker output lets downstream logic align word boundaries. An optional even-parity bit can be appended to each frame.

---
 rtl/serializer_pkg.sv | 17 +
 rtl/serializer_piso_bit_counter.sv | 33 +++
 rtl/serializer_piso.sv | 157 +++++++++++++++
 tb/tb_serializer_piso.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared types and constants for the PISO serializer.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bit-index counter width for a given word width (legal widths are >= 2).
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serializer_piso_bit_counter.sv
// Resettable, clearable up-counter that holds at a programmable limit.
//   clk, reset : clock, async active-low reset
//   clear      : synchronous return to zero (wins over en)
//   en         : advance by one unless already at limit
//   limit      : terminal count
//   count      : current value (registered)
//   at_limit_c : count == limit (combinational)
module bit_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         at_limit_c
);

  assign at_limit_c = (count == limit);

  // Count register; never advances past the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !at_limit_c) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/serializer_piso.sv
// Parallel-in/serial-out serializer, LSB first, with frame markers.
// Optional even-parity bit per frame when SERIALIZER_PARITY_EN is defined.
//   clk, reset   : clock, async active-low reset
//   data_in      : parallel word, sampled on an accepted load
//   load_valid   : upstream word available
//   load_ready   : can accept a word this cycle (combinational)
//   serial_out   : current serial bit
//   serial_valid : serial_out carries a frame bit
//   frame_start  : first bit of a frame
//   frame_last   : final bit of a frame (data MSB or parity bit)
module serializer_piso
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_last
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
`ifndef SERIALIZER_PARITY_EN
  localparam logic [CW-1:0] PRE_LAST_IDX = CW'(WIDTH - 2);
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             serial_out_d, serial_valid_d, frame_start_d, frame_last_d;
  logic [CW-1:0]    cnt;
  logic             cnt_at_limit_c, cnt_clear, cnt_en;
  logic             accept;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Counter holds the index of the bit currently on serial_out.
  bit_counter #(.W(CW)) u_bit_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (cnt_clear),
    .en         (cnt_en),
    .limit      (LAST_IDX),
    .count      (cnt),
    .at_limit_c (cnt_at_limit_c)
  );

  // Load window: idle, or the final bit of the current frame.
  always_comb begin
    load_ready = 1'b0;
    if (reset) begin
`ifdef SERIALIZER_PARITY_EN
      load_ready = (state_q == IDLE) || (state_q == PARITY);
`else
      load_ready = (state_q == IDLE) || ((state_q == SHIFT) && cnt_at_limit_c);
`endif
    end
  end

  assign accept = load_valid && load_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    serial_out_d   = 1'b0;
    serial_valid_d = 1'b0;
    frame_start_d  = 1'b0;
    frame_last_d   = 1'b0;
    cnt_clear      = 1'b0;
    cnt_en         = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d       = parity_q;
`endif

    if (accept) begin
      // New word: bit 0 goes out next cycle, even from a frame's last bit.
      state_d        = SHIFT;
      shreg_d        = data_in;
      serial_out_d   = data_in[0];
      serial_valid_d = 1'b1;
      frame_start_d  = 1'b1;
      cnt_clear      = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      parity_d       = ^data_in;
`endif
    end else begin
      case (state_q)
        IDLE: begin
        end
        SHIFT: begin
          if (!cnt_at_limit_c) begin
            cnt_en         = 1'b1;
            shreg_d        = shreg_q >> 1;
            serial_out_d   = shreg_q[1];
            serial_valid_d = 1'b1;
`ifndef SERIALIZER_PARITY_EN
            frame_last_d   = (cnt == PRE_LAST_IDX);
`endif
          end else begin
`ifdef SERIALIZER_PARITY_EN
            state_d        = PARITY;
            serial_out_d   = parity_q;
            serial_valid_d = 1'b1;
            frame_last_d   = 1'b1;
`else
            state_d        = IDLE;
            cnt_clear      = 1'b1;
`endif
          end
        end
`ifdef SERIALIZER_PARITY_EN
        PARITY: begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end
`endif
        default: begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      frame_last   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      serial_out   <= serial_out_d;
      serial_valid <= serial_valid_d;
      frame_start  <= frame_start_d;
      frame_last   <= frame_last_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_serializer_piso.sv
// Directed bench for serializer_piso (WIDTH=8); honours SERIALIZER_PARITY_EN.
module tb_serializer_piso;

`ifdef SERIALIZER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       load_valid;
  logic       load_ready;
  logic       serial_out;
  logic       serial_valid;
  logic       frame_start;
  logic       frame_last;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs [6];

  serializer_piso #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .frame_last   (frame_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Check one frame cycle k (0-based) at the current sample point.
  task automatic expect_cycle(input int k, input logic [7:0] d, input logic p, input string tag);
    logic e;
    e = (k < 8) ? d[k] : p;
    chk($sformatf("%s c%0d serial_valid", tag, k), 64'(serial_valid), 64'd1);
    chk($sformatf("%s c%0d serial_out", tag, k), 64'(serial_out), 64'(e));
    chk($sformatf("%s c%0d frame_start", tag, k), 64'(frame_start), 64'(k == 0));
    chk($sformatf("%s c%0d frame_last", tag, k), 64'(frame_last), 64'(k == FL - 1));
    chk($sformatf("%s c%0d load_ready", tag, k), 64'(load_ready), 64'(k == FL - 1));
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, " serial_valid"}, 64'(serial_valid), 64'd0);
    chk({tag, " serial_out"}, 64'(serial_out), 64'd0);
    chk({tag, " frame_start"}, 64'(frame_start), 64'd0);
    chk({tag, " frame_last"}, 64'(frame_last), 64'd0);
    chk({tag, " load_ready"}, 64'(load_ready), 64'd1);
  endtask

  // Load one word from idle, corrupt data_in afterwards, check the full frame.
  task automatic run_frame(input logic [7:0] d, input logic p, input string tag);
    @(negedge clk);
    chk({tag, " ready before load"}, 64'(load_ready), 64'd1);
    load_valid = 1'b1;
    data_in    = d;
    @(negedge clk);
    load_valid = 1'b0;
    data_in    = ~d;
    for (int k = 0; k < FL; k++) begin
      expect_cycle(k, d, p, tag);
      @(negedge clk);
    end
    expect_idle({tag, " after"});
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, par: 1'b0};
    vecs[1] = '{data: 8'h07, par: 1'b1};
    vecs[2] = '{data: 8'h01, par: 1'b1};
    vecs[3] = '{data: 8'h3C, par: 1'b0};
    vecs[4] = '{data: 8'hFF, par: 1'b0};
    vecs[5] = '{data: 8'h80, par: 1'b1};

    reset      = 1'b0;
    load_valid = 1'b0;
    data_in    = 8'h00;

    // Reset held for 3 cycles.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst c%0d serial_valid", c), 64'(serial_valid), 64'd0);
      chk($sformatf("rst c%0d serial_out", c), 64'(serial_out), 64'd0);
      chk($sformatf("rst c%0d frame_start", c), 64'(frame_start), 64'd0);
      chk($sformatf("rst c%0d frame_last", c), 64'(frame_last), 64'd0);
      chk($sformatf("rst c%0d load_ready", c), 64'(load_ready), 64'd0);
    end
    reset = 1'b1;

    // Idle for 10 cycles with no load.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      expect_idle($sformatf("idle c%0d", c));
    end

    // Table-driven single frames.
    foreach (vecs[i]) begin
      run_frame(vecs[i].data, vecs[i].par, $sformatf("vec%0d_%02h", i, vecs[i].data));
    end

    // Back-to-back: FF then 00 with load_valid held high.
    @(negedge clk);
    load_valid = 1'b1;
    data_in    = 8'hFF;
    @(negedge clk);
    data_in = 8'h00;
    for (int k = 0; k < FL; k++) begin
      expect_cycle(k, 8'hFF, 1'b0, "b2b0");
      @(negedge clk);
    end
    load_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      expect_cycle(k, 8'h00, 1'b0, "b2b1");
      @(negedge clk);
    end
    expect_idle("b2b after");

    // Reset mid-frame after bit 3.
    @(negedge clk);
    load_valid = 1'b1;
    data_in    = 8'hFF;
    @(negedge clk);
    load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_cycle(k, 8'hFF, 1'b0, "midrst");
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    chk("midrst async serial_valid", 64'(serial_valid), 64'd0);
    chk("midrst async serial_out", 64'(serial_out), 64'd0);
    chk("midrst async frame_start", 64'(frame_start), 64'd0);
    chk("midrst async frame_last", 64'(frame_last), 64'd0);
    chk("midrst async load_ready", 64'(load_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    expect_idle("midrst released");
    run_frame(8'h01, 1'b1, "post_rst_01");

    // Load pulse during cycle 4 of an A5 frame must be ignored.
    @(negedge clk);
    load_valid = 1'b1;
    data_in    = 8'hA5;
    @(negedge clk);
    load_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      if (k == 3) begin
        load_valid = 1'b1;
        data_in    = 8'h3C;
      end else begin
        load_valid = 1'b0;
      end
      expect_cycle(k, 8'hA5, 1'b0, "ignored");
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      expect_idle($sformatf("ignored after c%0d", c));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
